// File: rtl/param_regfile_sb.sv
// Parameterised register file with a per-entry pending-write scoreboard and a registered busy count.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to the read ports.
module param_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              wrtEn,
  input  logic [ADDR_W-1:0] wrtReg,
  input  logic [DATA_W-1:0] wrtData,
  input  logic              issueEn,
  input  logic [ADDR_W-1:0] issueReg,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rdReg1,
  input  logic [ADDR_W-1:0] rdReg2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic              rdBusy1,
  output logic              rdBusy2,
  output logic [ADDR_W:0]   busyCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_count_q;
  logic [ADDR_W:0]   busy_count_d;
  logic              wrt_ok;
  logic              issue_ok;

  logic [ADDR_W-1:0] rd_idx  [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  // Index 0 is inert when it is the hardwired zero register.
  function automatic logic idx_live(input logic [ADDR_W-1:0] idx);
    return !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    wrt_ok   = wrtEn && idx_live(wrtReg);
    issue_ok = issueEn && idx_live(issueReg);
  end

  // Issue is applied last so it wins over both flush and a same-index writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (wrt_ok) begin
      busy_d[wrtReg] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issueReg] = 1'b1;
    end
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        data_d[gi] = data_q[gi];
        if (wrt_ok && (wrtReg == ADDR_W'(gi))) begin
          data_d[gi] = wrtData;
        end
      end

      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          data_q[gi] <= '0;
        end else begin
          data_q[gi] <= data_d[gi];
        end
      end
    end
  endgenerate

  assign rd_idx[0] = rdReg1;
  assign rd_idx[1] = rdReg2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = '0;
        rd_busy[gi] = 1'b0;
        if (idx_live(rd_idx[gi])) begin
          rd_data[gi] = data_q[rd_idx[gi]];
          rd_busy[gi] = busy_q[rd_idx[gi]];
        end
`ifdef REGFILE_BYPASS_EN
        // A writeback in flight supplies the value and retires the pending mark early.
        if (wrt_ok && (wrtReg == rd_idx[gi])) begin
          rd_data[gi] = wrtData;
          rd_busy[gi] = 1'b0;
        end
`endif
      end
    end
  endgenerate

  assign rdData1   = rd_data[0];
  assign rdData2   = rd_data[1];
  assign rdBusy1   = rd_busy[0];
  assign rdBusy2   = rd_busy[1];
  assign busyCount = busy_count_q;

endmodule

// File: tb/tb_param_regfile_sb.sv
// Randomised and directed bench for param_regfile_sb against an array-based reference model,
// plus a directed run of a DATA_W=16 / ADDR_W=3 instance.
module tb_param_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic        we, ie, fl;
  logic [4:0]  wr, ir, r1, r2;
  logic [31:0] wd;
  logic [31:0] d1, d2;
  logic        bz1, bz2;
  logic [5:0]  bc;

  logic        b_we, b_ie, b_fl;
  logic [2:0]  b_wr, b_ir, b_r1, b_r2;
  logic [15:0] b_wd, b_d1, b_d2;
  logic        b_bz1, b_bz2;
  logic [3:0]  b_bc;

  param_regfile_sb dut (
    .clk(clk), .rst_(rst_),
    .wrtEn(we), .wrtReg(wr), .wrtData(wd),
    .issueEn(ie), .issueReg(ir), .flush(fl),
    .rdReg1(r1), .rdReg2(r2),
    .rdData1(d1), .rdData2(d2),
    .rdBusy1(bz1), .rdBusy2(bz2),
    .busyCount(bc)
  );

  param_regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_small (
    .clk(clk), .rst_(rst_),
    .wrtEn(b_we), .wrtReg(b_wr), .wrtData(b_wd),
    .issueEn(b_ie), .issueReg(b_ir), .flush(b_fl),
    .rdReg1(b_r1), .rdReg2(b_r2),
    .rdData1(b_d1), .rdData2(b_d2),
    .rdBusy1(b_bz1), .rdBusy2(b_bz2),
    .busyCount(b_bc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: plain arrays updated by the architectural rules.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  logic [31:0] pre_d1;
  logic        pre_bz1;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (we && wr != 0) begin
      m_mem[wr]  = wd;
      m_busy[wr] = 1'b0;
    end
    if (ie && ir != 0) m_busy[ir] = 1'b1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] pre_data(input logic [4:0] idx);
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return m_mem[idx];
  endfunction

  function automatic logic pre_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == idx) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  task automatic cycle(input string name, input logic we_i, input logic [4:0] wr_i,
                       input logic [31:0] wd_i, input logic ie_i, input logic [4:0] ir_i,
                       input logic fl_i, input logic [4:0] r1_i, input logic [4:0] r2_i);
    @(negedge clk);
    we = we_i; wr = wr_i; wd = wd_i; ie = ie_i; ir = ir_i; fl = fl_i; r1 = r1_i; r2 = r2_i;
    #1;
    pre_d1 = d1;
    pre_bz1 = bz1;
    check({name, "_pre_d1"}, 64'(d1), 64'(pre_data(r1)));
    check({name, "_pre_bz1"}, 64'(bz1), 64'(pre_busy(r1)));
    check({name, "_pre_d2"}, 64'(d2), 64'(pre_data(r2)));
    check({name, "_pre_bz2"}, 64'(bz2), 64'(pre_busy(r2)));
    @(posedge clk);
    model_edge();
    #1;
    we = 1'b0; ie = 1'b0; fl = 1'b0;
    #1;
    check({name, "_d1"}, 64'(d1), 64'(m_mem[r1]));
    check({name, "_bz1"}, 64'(bz1), 64'(m_busy[r1]));
    check({name, "_d2"}, 64'(d2), 64'(m_mem[r2]));
    check({name, "_bz2"}, 64'(bz2), 64'(m_busy[r2]));
    check({name, "_cnt"}, 64'(bc), 64'(model_count()));
    $display("txn %-8s we=%0d wr=%0d wd=%h ie=%0d ir=%0d fl=%0d -> cnt=%0d",
             name, we_i, wr_i, wd_i, ie_i, ir_i, fl_i, bc);
  endtask

  int saved_cnt;

  initial begin
    rst_ = 1'b0;
    we = 0; wr = 0; wd = 0; ie = 0; ir = 0; fl = 0; r1 = 0; r2 = 0;
    b_we = 0; b_wr = 0; b_wd = 0; b_ie = 0; b_ir = 0; b_fl = 0; b_r1 = 0; b_r2 = 0;
    model_reset();
    #12;
    check("rst_cnt", 64'(bc), 64'd0);
    check("rst_small_cnt", 64'(b_bc), 64'd0);
    @(negedge clk);
    rst_ = 1'b1;

    // Reset mid-operation, with a write and an issue pending across an edge.
    cycle("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
    cycle("iss6", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd5, 5'd6);
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    we = 1'b1; wr = 5'd7; wd = 32'h1234_5678; ie = 1'b1; ir = 5'd9;
    #1;
    model_reset();
    check("rst_r5", 64'(d1), 64'd0);
    check("rst_r6_busy", 64'(bz2), 64'd0);
    check("rst_now_cnt", 64'(bc), 64'd0);
    @(posedge clk);
    #1;
    check("rst_edge_cnt", 64'(bc), 64'd0);
    @(negedge clk);
    we = 1'b0; ie = 1'b0;
    rst_ = 1'b1;
    r1 = 5'd7; r2 = 5'd9;
    #1;
    check("rst_discard_d", 64'(d1), 64'd0);
    check("rst_discard_bz", 64'(bz2), 64'd0);
    $display("txn reset    r5/r6 cleared, pending write/issue discarded");

    // Zero register.
    saved_cnt = int'(bc);
    cycle("zero", 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    check("zero_d1", 64'(d1), 64'd0);
    check("zero_bz1", 64'(bz1), 64'd0);
    check("zero_cnt", 64'(bc), 64'(saved_cnt));

    // Scoreboard.
    cycle("iss3", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd7);
    cycle("iss7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd3, 5'd7);
    check("sb_cnt2", 64'(bc), 64'd2);
    cycle("wr3", 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7);
    check("sb_bz3", 64'(bz1), 64'd0);
    check("sb_d3", 64'(d1), 64'hA5);
    check("sb_cnt1", 64'(bc), 64'd1);

    // Collision and flush.
    cycle("coll9", 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd9, 5'd7);
    check("coll_bz9", 64'(bz1), 64'd1);
    check("coll_d9", 64'(d1), 64'h55);
    cycle("flush4", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9);
    check("flush_cnt", 64'(bc), 64'd1);
    check("flush_bz4", 64'(bz1), 64'd1);
    check("flush_bz9", 64'(bz2), 64'd0);

    // Read-during-write on r2 while r2 is pending.
    cycle("prep2", 1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 1'b0, 5'd2, 5'd2);
    cycle("byp2", 1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 1'b0, 5'd2, 5'd2);
`ifdef REGFILE_BYPASS_EN
    check("byp_d1", 64'(pre_d1), 64'h77);
    check("byp_bz1", 64'(pre_bz1), 64'd0);
`else
    check("byp_d1", 64'(pre_d1), 64'h11);
    check("byp_bz1", 64'(pre_bz1), 64'd1);
`endif

    // Random traffic biased to low indices so issues, writes and flushes collide.
    for (int t = 0; t < 150; t++) begin
      logic [4:0] rw, ri, ra, rb;
      rw = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ri = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      cycle("rand", 1'($urandom_range(0, 1)), rw, $urandom, 1'($urandom_range(0, 1)), ri,
            1'($urandom_range(0, 9) == 0), ra, rb);
    end

    // Narrow instance: fill every live entry, including an ignored issue to r0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_ie = 1'b1; b_ir = 3'(i);
      @(posedge clk);
      #1;
      b_ie = 1'b0;
      $display("txn small    issue r%0d -> cnt=%0d", i, b_bc);
    end
    check("small_cnt7", 64'(b_bc), 64'd7);
    @(negedge clk);
    b_we = 1'b1; b_wr = 3'd7; b_wd = 16'hFFFF;
    @(posedge clk);
    #1;
    b_we = 1'b0; b_r1 = 3'd7; b_r2 = 3'd0;
    #1;
    $display("txn small    write r7=ffff -> cnt=%0d", b_bc);
    check("small_d7", 64'(b_d1), 64'hFFFF);
    check("small_bz7", 64'(b_bz1), 64'd0);
    check("small_cnt6", 64'(b_bc), 64'd6);
    check("small_r0_bz", 64'(b_bz2), 64'd0);
    check("small_r0_d", 64'(b_d2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_regfile_sb.md
PARAM_REGFILE_SB -- requirements
Module: param_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero and never busy.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wrtEn  input  1  writeback enable.
REQ-007 SHALL have port wrtReg  input  ADDR_W  writeback index.
REQ-008 SHALL have port wrtData  input  DATA_W  writeback data.
REQ-009 SHALL have port issueEn  input  1  marks issueReg as pending a write.
REQ-010 SHALL have port issueReg  input  ADDR_W  index being issued.
REQ-011 SHALL have port flush  input  1  clears all pending marks.
REQ-012 SHALL have ports rdReg1, rdReg2  input  ADDR_W  read indices.
REQ-013 SHALL have ports rdData1, rdData2  output  DATA_W  combinational read data.
REQ-014 SHALL have ports rdBusy1, rdBusy2  output  1  combinational pending flag of the read index.
REQ-015 SHALL have port busyCount  output  ADDR_W+1  registered count of busy registers.

Function
REQ-016 SHALL store wrtData into entry wrtReg on the rising clk edge when wrtEn=1; read ports reflect it the same cycle after the edge (zero-latency read).
REQ-017 SHALL, with ZERO_REG=1, ignore writes and issues to index 0 and always return 0 and busy=0 for index 0.
REQ-018 SHALL keep busy[i], one bit per entry: issueEn sets busy[issueReg]; wrtEn clears busy[wrtReg].
REQ-019 SHALL resolve same-edge issue and write to the same index as set (new writer pending).
REQ-020 SHALL, on flush=1, clear every busy bit at the edge; a simultaneous issueEn still sets busy[issueReg] (issue wins over flush); a simultaneous write still updates data.
REQ-021 SHALL update busyCount to the population count of the next-state busy vector each edge; busyCount never exceeds 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1).
REQ-022 SHALL produce no change when issueEn sets an already-busy entry or wrtEn clears a non-busy entry, except data storage.
REQ-023 SHALL allow both read ports to address the same index, returning identical values.

Reset
REQ-024 SHALL, while rst_=0, immediately clear all entries to 0, all busy bits to 0 and busyCount to 0, regardless of clk.
REQ-025 SHALL, on rst_ asserted mid-operation, discard any same-cycle write/issue; first update occurs on the first rising clk after rst_ rises.

Configuration
REQ-026 SHALL, when REGFILE_BYPASS_EN is defined, return wrtData on rdDataN and 0 on rdBusyN whenever wrtEn=1 and wrtReg=rdRegN (index 0 excluded when ZERO_REG=1), before the edge.
REQ-027 SHALL, when REGFILE_BYPASS_EN is not defined, return only stored contents and stored busy bits; a same-cycle write becomes visible after the edge.

Verification
REQ-028 SHALL test reset: write 0xDEADBEEF to r5, issue r6, assert rst_=0 between edges -> rdData(r5)=0, rdBusy(r6)=0, busyCount=0 immediately.
REQ-029 SHALL test zero register: write 0x12345678 to r0 and issue r0 -> rdData1(r0)=0, rdBusy1=0, busyCount unchanged.
REQ-030 SHALL test scoreboard: issue r3, r7 on two edges -> busyCount=2; write r3=0xA5 -> rdBusy(r3)=0, rdData=0xA5, busyCount=1.
REQ-031 SHALL test collision: issue r9 and write r9=0x55 on the same edge -> rdBusy(r9)=1, rdData(r9)=0x55; flush with issue r4 -> busyCount=1, only r4 busy.
REQ-032 SHALL test bypass: wrtEn=1, wrtReg=r2, wrtData=0x77, rdReg1=r2 pre-edge -> rdData1=0x77, rdBusy1=0 with REGFILE_BYPASS_EN; old value and stored busy without it.
REQ-033 SHALL test parameters DATA_W=16, ADDR_W=3: issue all 7 non-zero entries -> busyCount=7; write 0xFFFF to r7 -> rdData=0xFFFF, busyCount=6.
